inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  encoder can accept a command
- cmd_kind_i  in  5  instruction kind (REQ-006)
- cmd_rs_i  in  5  rs field
- cmd_rt_i  in  5  rt field
- cmd_rd_i  in  5  rd field
- cmd_sa_i  in  5  shift amount
- cmd_imm_i  in  16  immediate
- flush_i  in  1  discard all queued words
- inst_valid_o  out  1  head word available
- inst_ready_i  in  1  consumer takes head word
- inst_o  out  32  encoded instruction at FIFO head
- inst_addr_o  out  32  byte address paired with inst_o
- err_o  out  1  one-cycle pulse on invalid kind
- err_cnt_o  out  8  saturating invalid-kind count
REQ-003 SHALL use parameter DEPTH, default 8, as the FIFO depth in words (power of two).

Function
REQ-004 SHALL accept a command when cmd_valid_i && cmd_ready_o at a rising edge.
REQ-005 SHALL drive cmd_ready_o = (count < DEPTH) && !rst; no push when full, even with a same-cycle pop.
REQ-006 SHALL encode kinds as follows:
- 0 NOP: 0x00000000
- 1 OR: funct 100101
- 2 AND: funct 100100
- 3 XOR: funct 100110
- 4 NOR: funct 100111
- 5 SLLV: funct 000100
- 6 SRLV: funct 000110
- 7 SRAV: funct 000111
- 8 SLL: funct 000000
- 9 SRL: funct 000010
- 10 SRA: funct 000011
- 11 ORI: op 001101
- 12 ANDI: op 001100
- 13 XORI: op 001110
- 14 LUI: op 001111
- 15 SYNC: 0x0000000F
- 16 PREF: op 110011
REQ-007 SHALL format kinds 1-7 as {000000, rs, rt, rd, 00000, funct}.
REQ-008 SHALL format kinds 8-10 as {000000, 00000, rt, rd, sa, funct}; cmd_rs_i is ignored.
REQ-009 SHALL format kinds 11-13 and 16 as {op, rs, rt, imm}.
REQ-010 SHALL format LUI as {001111, 00000, rt, imm}.
REQ-011 SHALL treat kinds 17-31 as invalid:
- command is accepted but nothing is written to the FIFO
- err_o is high for exactly the next cycle
- err_cnt_o increments, saturating at 255
REQ-012 SHALL write each valid accepted command into the FIFO at the accepting edge. inst_valid_o and inst_o reflect the word from the following cycle (1-cycle latency when empty).
REQ-013 SHALL pop the head when inst_valid_o && inst_ready_i. inst_valid_o = (count != 0).
REQ-014 SHALL keep count unchanged on a simultaneous push and pop when not full. SHALL keep order FIFO. Pointers wrap modulo DEPTH.
REQ-015 SHALL hold inst_o and inst_addr_o stable while inst_valid_o && !inst_ready_i.
REQ-016 SHALL start inst_addr_o at 0 and add 4 per pop, wrapping modulo 2^32.
REQ-017 SHALL apply flush_i as follows:
- count and both pointers clear at the edge
- flush has priority over push and pop in the same cycle
- inst_addr_o and err_cnt_o are unaffected
- an invalid kind accepted in the same cycle still pulses err_o

Reset
REQ-018 SHALL, while rst is high at an edge, clear count, pointers, inst_addr_o, err_o and err_cnt_o.
REQ-019 SHALL hold cmd_ready_o and inst_valid_o low during reset. inst_o SHALL read 0 when empty.
REQ-020 SHALL discard in-flight FIFO contents on reset mid-operation. The first post-reset word SHALL appear at address 0.

Verification
REQ-021 SHALL cover ORI rs=1, rt=2, imm=0x1234 -> inst_o=0x34221234 one cycle later, inst_addr_o=0.
REQ-022 SHALL cover OR rs=1, rt=2, rd=3, then SLL rs=31, rt=2, rd=3, sa=4 -> 0x00221825 then 0x00021900, addresses 0 and 4.
REQ-023 SHALL cover LUI rs=7, rt=5, imm=0xABCD -> 0x3C05ABCD (rs ignored); SYNC -> 0x0000000F.
REQ-024 SHALL cover overflow:
- 9 pushes with inst_ready_i=0 -> cmd_ready_o low after 8th, 9th held
- one pop -> cmd_ready_o high next cycle, 9th accepted
- draining all -> last inst_addr_o=0x20
REQ-025 SHALL cover kind=17 -> err_o one-cycle pulse, err_cnt_o=1, inst_valid_o stays 0; 256 invalid kinds -> err_cnt_o=255.
REQ-026 SHALL cover edge interactions:
- flush_i with 3 queued and a same-cycle push -> inst_valid_o=0 next cycle, inst_addr_o unchanged
- rst mid-fill -> all outputs at reset values

Source files
------------

// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder
//
// Turns abstract instruction commands (kind + register/immediate fields) into
// 32-bit MIPS-style machine words and queues them in a small FIFO. Each word
// leaves the FIFO paired with a running byte address that advances by 4 per
// word consumed. Unknown kinds are swallowed, pulse err_o and bump a
// saturating error counter.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous, active-high reset
//   cmd_valid_i   command present
//   cmd_ready_o   encoder can accept a command (FIFO not full, not in reset)
//   cmd_kind_i    instruction kind, 0..16 valid, 17..31 invalid
//   cmd_rs_i      rs field
//   cmd_rt_i      rt field
//   cmd_rd_i      rd field
//   cmd_sa_i      shift amount
//   cmd_imm_i     16-bit immediate
//   flush_i       discard all queued words
//   inst_valid_o  a word is available at the FIFO head
//   inst_ready_i  consumer takes the head word
//   inst_o        encoded word at the FIFO head (0 when empty)
//   inst_addr_o   byte address paired with inst_o
//   err_o         one-cycle pulse after an invalid kind is accepted
//   err_cnt_o     saturating count of invalid kinds
//
// Parameter
//   DEPTH         FIFO depth in words, must be a power of two
// ---------------------------------------------------------------------------
module inst_encoder #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [4:0]  cmd_kind_i,
   input  logic [4:0]  cmd_rs_i,
   input  logic [4:0]  cmd_rt_i,
   input  logic [4:0]  cmd_rd_i,
   input  logic [4:0]  cmd_sa_i,
   input  logic [15:0] cmd_imm_i,
   input  logic        flush_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        err_o,
   output logic [7:0]  err_cnt_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Instruction kinds as they arrive on cmd_kind_i.
   typedef enum logic [4:0] {
      KIND_NOP  = 5'd0,
      KIND_OR   = 5'd1,
      KIND_AND  = 5'd2,
      KIND_XOR  = 5'd3,
      KIND_NOR  = 5'd4,
      KIND_SLLV = 5'd5,
      KIND_SRLV = 5'd6,
      KIND_SRAV = 5'd7,
      KIND_SLL  = 5'd8,
      KIND_SRL  = 5'd9,
      KIND_SRA  = 5'd10,
      KIND_ORI  = 5'd11,
      KIND_ANDI = 5'd12,
      KIND_XORI = 5'd13,
      KIND_LUI  = 5'd14,
      KIND_SYNC = 5'd15,
      KIND_PREF = 5'd16
   } kind_e;

   // Function codes for the SPECIAL (opcode 0) group.
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_XOR  = 6'b100110;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLLV = 6'b000100;
   localparam logic [5:0] FUNCT_SRLV = 6'b000110;
   localparam logic [5:0] FUNCT_SRAV = 6'b000111;
   localparam logic [5:0] FUNCT_SLL  = 6'b000000;
   localparam logic [5:0] FUNCT_SRL  = 6'b000010;
   localparam logic [5:0] FUNCT_SRA  = 6'b000011;

   // Primary opcodes for the immediate group.
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_XORI = 6'b001110;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_PREF = 6'b110011;

   // Register-register logic/variable-shift layout: shamt field is zero.
   function automatic logic [31:0] reg_word(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [5:0] funct);
      reg_word = {6'b000000, rs, rt, rd, 5'b00000, funct};
   endfunction

   // Constant-shift layout: rs slot is forced to zero, shamt carries sa.
   function automatic logic [31:0] shift_word(input logic [4:0] rt, input logic [4:0] rd,
                                              input logic [4:0] sa, input logic [5:0] funct);
      shift_word = {6'b000000, 5'b00000, rt, rd, sa, funct};
   endfunction

   // Immediate layout shared by ORI/ANDI/XORI/PREF.
   function automatic logic [31:0] imm_word(input logic [5:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [15:0] imm);
      imm_word = {op, rs, rt, imm};
   endfunction

   logic [31:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic [31:0] enc_word;
   logic        kind_valid;
   logic        accept;
   logic        push;
   logic        pop;
   logic        err_event;

   // Handshake side. The FIFO refuses commands as soon as it is full, even if
   // the head is being popped in the same cycle, so the ready path never
   // depends on inst_ready_i. Reset forces both ready and valid low because
   // the count register is only cleared at the first reset edge.
   always_comb begin
      cmd_ready_o  = (count < DEPTH_C) && !rst;
      inst_valid_o = (count != '0) && !rst;
      inst_o       = inst_valid_o ? mem[rd_ptr] : 32'd0;
   end

   // Encoder: translate the command fields into a machine word. Anything
   // outside the known kinds is flagged invalid and produces no word.
   always_comb begin
      enc_word   = 32'd0;
      kind_valid = 1'b1;
      case (cmd_kind_i)
         KIND_NOP:  enc_word = 32'h0000_0000;
         KIND_OR:   enc_word = reg_word(cmd_rs_i, cmd_rt_i, cmd_rd_i, FUNCT_OR);
         KIND_AND:  enc_word = reg_word(cmd_rs_i, cmd_rt_i, cmd_rd_i, FUNCT_AND);
         KIND_XOR:  enc_word = reg_word(cmd_rs_i, cmd_rt_i, cmd_rd_i, FUNCT_XOR);
         KIND_NOR:  enc_word = reg_word(cmd_rs_i, cmd_rt_i, cmd_rd_i, FUNCT_NOR);
         KIND_SLLV: enc_word = reg_word(cmd_rs_i, cmd_rt_i, cmd_rd_i, FUNCT_SLLV);
         KIND_SRLV: enc_word = reg_word(cmd_rs_i, cmd_rt_i, cmd_rd_i, FUNCT_SRLV);
         KIND_SRAV: enc_word = reg_word(cmd_rs_i, cmd_rt_i, cmd_rd_i, FUNCT_SRAV);
         KIND_SLL:  enc_word = shift_word(cmd_rt_i, cmd_rd_i, cmd_sa_i, FUNCT_SLL);
         KIND_SRL:  enc_word = shift_word(cmd_rt_i, cmd_rd_i, cmd_sa_i, FUNCT_SRL);
         KIND_SRA:  enc_word = shift_word(cmd_rt_i, cmd_rd_i, cmd_sa_i, FUNCT_SRA);
         KIND_ORI:  enc_word = imm_word(OP_ORI, cmd_rs_i, cmd_rt_i, cmd_imm_i);
         KIND_ANDI: enc_word = imm_word(OP_ANDI, cmd_rs_i, cmd_rt_i, cmd_imm_i);
         KIND_XORI: enc_word = imm_word(OP_XORI, cmd_rs_i, cmd_rt_i, cmd_imm_i);
         KIND_LUI:  enc_word = imm_word(OP_LUI, 5'b00000, cmd_rt_i, cmd_imm_i);
         KIND_SYNC: enc_word = 32'h0000_000F;
         KIND_PREF: enc_word = imm_word(OP_PREF, cmd_rs_i, cmd_rt_i, cmd_imm_i);
         default: begin
            enc_word   = 32'd0;
            kind_valid = 1'b0;
         end
      endcase
   end

   // Transfer qualifiers. An accepted invalid kind still reports its error
   // during a flush; a flush simply suppresses any FIFO movement.
   always_comb begin
      accept    = cmd_valid_i && cmd_ready_o;
      err_event = accept && !kind_valid;
      push      = accept && kind_valid && !flush_i;
      pop       = inst_valid_o && inst_ready_i && !flush_i;
   end

   // Storage array. Not reset: stale entries are unreachable because inst_o
   // is gated by the count, and push is already blocked while in reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= enc_word;
      end
   end

   // Pointers and occupancy. Flush empties the queue but leaves the address
   // counter alone, so the stream of addresses continues where it stopped.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Byte address of the head word: one word (4 bytes) further on every pop,
   // wrapping naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_addr_o <= 32'd0;
      end else if (pop) begin
         inst_addr_o <= inst_addr_o + 32'd4;
      end
   end

   // Error reporting: the pulse lands in the cycle after the bad command was
   // accepted, and the counter sticks at 255 instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_o     <= 1'b0;
         err_cnt_o <= 8'd0;
      end else begin
         err_o <= err_event;
         if (err_event && (err_cnt_o != 8'hFF)) begin
            err_cnt_o <= err_cnt_o + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// ---------------------------------------------------------------------------
// tb_inst_encoder
//
// Self-checking bench for inst_encoder. A queue-based reference model tracks
// the words the encoder should be holding, the head address and the error
// state; a compare process checks every DUT output against it on each falling
// edge. Directed scenarios add literal expectations for known encodings,
// overflow, invalid kinds, flush and mid-fill reset.
// ---------------------------------------------------------------------------
module tb_inst_encoder;

   localparam int DEPTH = 8;

   logic        clk;
   logic        rst;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [4:0]  cmd_kind_i;
   logic [4:0]  cmd_rs_i;
   logic [4:0]  cmd_rt_i;
   logic [4:0]  cmd_rd_i;
   logic [4:0]  cmd_sa_i;
   logic [15:0] cmd_imm_i;
   logic        flush_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        err_o;
   logic [7:0]  err_cnt_o;

   int compared;
   int mismatched;

   inst_encoder #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_kind_i   (cmd_kind_i),
      .cmd_rs_i     (cmd_rs_i),
      .cmd_rt_i     (cmd_rt_i),
      .cmd_rd_i     (cmd_rd_i),
      .cmd_sa_i     (cmd_sa_i),
      .cmd_imm_i    (cmd_imm_i),
      .flush_i      (flush_i),
      .inst_valid_o (inst_valid_o),
      .inst_ready_i (inst_ready_i),
      .inst_o       (inst_o),
      .inst_addr_o  (inst_addr_o),
      .err_o        (err_o),
      .err_cnt_o    (err_cnt_o)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference encoding written from the instruction tables as plain
   // field arithmetic.
   function automatic int functOf(input int kind);
      case (kind)
         1: return 37;
         2: return 36;
         3: return 38;
         4: return 39;
         5: return 4;
         6: return 6;
         7: return 7;
         8: return 0;
         9: return 2;
         10: return 3;
         default: return 0;
      endcase
   endfunction

   function automatic int opOf(input int kind);
      case (kind)
         11: return 13;
         12: return 12;
         13: return 14;
         14: return 15;
         16: return 51;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] modelEncode(input int kind, input int rs, input int rt,
                                               input int rd, input int sa, input int imm);
      int w;
      w = 0;
      if (kind == 15) w = 15;
      else if (kind >= 1 && kind <= 7) w = (rs << 21) | (rt << 16) | (rd << 11) | functOf(kind);
      else if (kind >= 8 && kind <= 10) w = (rt << 16) | (rd << 11) | (sa << 6) | functOf(kind);
      else if (kind == 14) w = (opOf(kind) << 26) | (rt << 16) | imm;
      else if (kind >= 11) w = (opOf(kind) << 26) | (rs << 21) | (rt << 16) | imm;
      return w;
   endfunction

   // Reference model state.
   logic [31:0] mq[$];
   int          mAddr;
   int          mErrCnt;
   logic        mErrPulse;
   logic        modelLive;

   initial begin
      modelLive = 1'b0;
      mAddr     = 0;
      mErrCnt   = 0;
      mErrPulse = 1'b0;
   end

   // Model update on each rising edge from the inputs the DUT sees.
   always @(posedge clk) begin
      logic acc, bad, doPop;
      if (rst) begin
         mq.delete();
         mAddr     = 0;
         mErrCnt   = 0;
         mErrPulse = 1'b0;
         modelLive = 1'b1;
      end else begin
         acc       = cmd_valid_i && (mq.size() < DEPTH);
         bad       = acc && (int'(cmd_kind_i) > 16);
         mErrPulse = bad;
         if (bad && mErrCnt < 255) mErrCnt++;
         if (flush_i) begin
            mq.delete();
         end else begin
            doPop = (mq.size() != 0) && inst_ready_i;
            if (doPop) begin
               void'(mq.pop_front());
               mAddr = mAddr + 4;
            end
            if (acc && !bad)
               mq.push_back(modelEncode(int'(cmd_kind_i), int'(cmd_rs_i), int'(cmd_rt_i),
                                        int'(cmd_rd_i), int'(cmd_sa_i), int'(cmd_imm_i)));
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (modelLive) begin
         checkOutput("m_cmd_ready", {31'd0, cmd_ready_o}, {31'd0, (mq.size() < DEPTH) && !rst});
         checkOutput("m_inst_valid", {31'd0, inst_valid_o}, {31'd0, (mq.size() != 0) && !rst});
         checkOutput("m_inst", inst_o, ((mq.size() != 0) && !rst) ? mq[0] : 32'd0);
         checkOutput("m_addr", inst_addr_o, mAddr);
         checkOutput("m_err", {31'd0, err_o}, {31'd0, mErrPulse});
         checkOutput("m_err_cnt", {24'd0, err_cnt_o}, mErrCnt);
      end
   end

   // Advance one cycle; inputs change 1 time unit after the falling edge.
   task automatic stepCycle();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input int kind, input int rs, input int rt,
                                input int rd, input int sa, input int imm);
      cmd_valid_i = valid;
      cmd_kind_i  = 5'(kind);
      cmd_rs_i    = 5'(rs);
      cmd_rt_i    = 5'(rt);
      cmd_rd_i    = 5'(rd);
      cmd_sa_i    = 5'(sa);
      cmd_imm_i   = 16'(imm);
   endtask

   task automatic idle();
      cmd_valid_i = 1'b0;
   endtask

   task automatic doReset();
      rst          = 1'b1;
      cmd_valid_i  = 1'b0;
      flush_i      = 1'b0;
      inst_ready_i = 1'b0;
      stepCycle();
      rst = 1'b0;
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      rst          = 1'b1;
      flush_i      = 1'b0;
      inst_ready_i = 1'b0;
      applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
      stepCycle();
      stepCycle();

      // Reset state
      checkOutput("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
      checkOutput("rst_valid", {31'd0, inst_valid_o}, 32'd0);
      checkOutput("rst_inst", inst_o, 32'd0);
      checkOutput("rst_addr", inst_addr_o, 32'd0);
      checkOutput("rst_err", {31'd0, err_o}, 32'd0);
      checkOutput("rst_err_cnt", {24'd0, err_cnt_o}, 32'd0);
      rst = 1'b0;
      stepCycle();
      checkOutput("ready_after_rst", {31'd0, cmd_ready_o}, 32'd1);

      // ORI rs=1 rt=2 imm=0x1234
      applyStimulus(1'b1, 11, 1, 2, 0, 0, 'h1234);
      stepCycle();
      idle();
      checkOutput("ori_valid", {31'd0, inst_valid_o}, 32'd1);
      checkOutput("ori_word", inst_o, 32'h34221234);
      checkOutput("ori_addr", inst_addr_o, 32'd0);

      // OR then SLL (rs ignored), consumed in order
      doReset();
      applyStimulus(1'b1, 1, 1, 2, 3, 0, 0);
      stepCycle();
      applyStimulus(1'b1, 8, 31, 2, 3, 4, 0);
      stepCycle();
      idle();
      checkOutput("or_word", inst_o, 32'h00221825);
      checkOutput("or_addr", inst_addr_o, 32'd0);
      inst_ready_i = 1'b1;
      stepCycle();
      checkOutput("sll_word", inst_o, 32'h00021900);
      checkOutput("sll_addr", inst_addr_o, 32'd4);
      stepCycle();
      inst_ready_i = 1'b0;
      checkOutput("drained_valid", {31'd0, inst_valid_o}, 32'd0);
      checkOutput("drained_addr", inst_addr_o, 32'd8);

      // LUI (rs ignored) and SYNC
      doReset();
      applyStimulus(1'b1, 14, 7, 5, 0, 0, 'hABCD);
      stepCycle();
      applyStimulus(1'b1, 15, 3, 3, 3, 3, 'hFFFF);
      stepCycle();
      idle();
      checkOutput("lui_word", inst_o, 32'h3C05ABCD);
      inst_ready_i = 1'b1;
      stepCycle();
      inst_ready_i = 1'b0;
      checkOutput("sync_word", inst_o, 32'h0000000F);
      checkOutput("sync_addr", inst_addr_o, 32'd4);

      // Overflow: 9 pushes into an 8-deep FIFO with the consumer stalled
      doReset();
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, 11, 0, 0, 0, 0, i);
         stepCycle();
         if (i == 7) checkOutput("full_ready", {31'd0, cmd_ready_o}, 32'd0);
      end
      checkOutput("full_head_held", inst_o, 32'h34000000);
      inst_ready_i = 1'b1;
      stepCycle();
      inst_ready_i = 1'b0;
      checkOutput("ready_after_pop", {31'd0, cmd_ready_o}, 32'd1);
      stepCycle();
      idle();
      checkOutput("ninth_refull", {31'd0, cmd_ready_o}, 32'd0);
      inst_ready_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == 7) begin
            checkOutput("last_addr", inst_addr_o, 32'h20);
            checkOutput("last_word", inst_o, 32'h34000008);
         end
         stepCycle();
      end
      inst_ready_i = 1'b0;
      checkOutput("overflow_empty", {31'd0, inst_valid_o}, 32'd0);

      // Invalid kinds: pulse, count, saturation
      doReset();
      applyStimulus(1'b1, 17, 1, 1, 1, 1, 1);
      stepCycle();
      idle();
      checkOutput("inv_err_pulse", {31'd0, err_o}, 32'd1);
      checkOutput("inv_err_cnt", {24'd0, err_cnt_o}, 32'd1);
      checkOutput("inv_no_word", {31'd0, inst_valid_o}, 32'd0);
      stepCycle();
      checkOutput("inv_err_drop", {31'd0, err_o}, 32'd0);
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, 17 + (i % 15), i % 32, 0, 0, 0, i);
         stepCycle();
      end
      idle();
      stepCycle();
      checkOutput("inv_err_sat", {24'd0, err_cnt_o}, 32'd255);

      // Flush with 3 queued and a same-cycle push
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 11, 0, 0, 0, 0, 'h10 + i);
         stepCycle();
      end
      idle();
      inst_ready_i = 1'b1;
      stepCycle();
      inst_ready_i = 1'b0;
      checkOutput("pre_flush_addr", inst_addr_o, 32'd4);
      flush_i = 1'b1;
      applyStimulus(1'b1, 12, 2, 3, 0, 0, 'h7777);
      stepCycle();
      flush_i = 1'b0;
      idle();
      checkOutput("flush_valid", {31'd0, inst_valid_o}, 32'd0);
      checkOutput("flush_addr", inst_addr_o, 32'd4);
      flush_i = 1'b1;
      applyStimulus(1'b1, 25, 0, 0, 0, 0, 0);
      stepCycle();
      flush_i = 1'b0;
      idle();
      checkOutput("flush_err", {31'd0, err_o}, 32'd1);
      applyStimulus(1'b1, 11, 0, 1, 0, 0, 'h55);
      stepCycle();
      idle();
      checkOutput("post_flush_word", inst_o, 32'h34010055);
      checkOutput("post_flush_addr", inst_addr_o, 32'd4);

      // Reset in the middle of filling
      applyStimulus(1'b1, 2, 4, 5, 6, 0, 0);
      stepCycle();
      rst = 1'b1;
      stepCycle();
      checkOutput("midrst_ready", {31'd0, cmd_ready_o}, 32'd0);
      checkOutput("midrst_valid", {31'd0, inst_valid_o}, 32'd0);
      checkOutput("midrst_inst", inst_o, 32'd0);
      checkOutput("midrst_addr", inst_addr_o, 32'd0);
      checkOutput("midrst_err_cnt", {24'd0, err_cnt_o}, 32'd0);
      rst = 1'b0;
      applyStimulus(1'b1, 13, 1, 2, 0, 0, 'hBEEF);
      stepCycle();
      idle();
      checkOutput("midrst_first_word", inst_o, 32'h3822BEEF);
      checkOutput("midrst_first_addr", inst_addr_o, 32'd0);
      stepCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
